// File: rtl/mem_issue_queue.sv
// In-order memory-op issue queue with CDB operand snooping ahead of the MMU.
// Optional stall counters are enabled with MEM_ISSUE_QUEUE_PERF_EN.
module mem_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int RSV_ID_W = 4,
  parameter int INSTR_W  = 6,
  parameter int CDB_W    = RSV_ID_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RSV_ID_W-1:0]     in_rsv_id,
  input  logic [INSTR_W-1:0]      in_opcode,
  input  logic [DATA_W-1:0]       in_base,
  input  logic                    in_base_ok,
  input  logic [DATA_W-1:0]       in_offset,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_data_ok,
  input  logic [CDB_W-1:0]        cdb,
  input  logic                    cdb_fire,
  output logic                    mmu_valid,
  input  logic                    mmu_ready,
  output logic [RSV_ID_W-1:0]     mmu_rsv_id,
  output logic [INSTR_W-1:0]      mmu_opcode,
  output logic [DATA_W-1:0]       mmu_address,
  output logic [DATA_W-1:0]       mmu_data,
  output logic [$clog2(DEPTH):0]  count
`ifdef MEM_ISSUE_QUEUE_PERF_EN
  ,
  output logic [31:0]             perf_stall_operand,
  output logic [31:0]             perf_stall_mmu
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [RSV_ID_W-1:0] rsv_id_q  [DEPTH];
  logic [RSV_ID_W-1:0] rsv_id_d  [DEPTH];
  logic [INSTR_W-1:0]  opcode_q  [DEPTH];
  logic [INSTR_W-1:0]  opcode_d  [DEPTH];
  logic [DATA_W-1:0]   base_q    [DEPTH];
  logic [DATA_W-1:0]   base_d    [DEPTH];
  logic [DATA_W-1:0]   offset_q  [DEPTH];
  logic [DATA_W-1:0]   offset_d  [DEPTH];
  logic [DATA_W-1:0]   data_q    [DEPTH];
  logic [DATA_W-1:0]   data_d    [DEPTH];
  logic [DEPTH-1:0]    base_ok_q, base_ok_d;
  logic [DEPTH-1:0]    data_ok_q, data_ok_d;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [RSV_ID_W-1:0] cdb_tag;
  logic [DATA_W-1:0]   cdb_val;
  logic [DEPTH-1:0]    occupied;
  logic                nonempty, head_ok, push, pop;

  assign cdb_tag = cdb[CDB_W-1 -: RSV_ID_W];
  assign cdb_val = cdb[DATA_W-1:0];

  // An entry is live when its distance from head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    assign occupied[gi] = {1'b0, PTR_W'(gi) - head_q} < count_q;
  end

  assign nonempty    = (count_q != '0);
  assign head_ok     = base_ok_q[head_q] && data_ok_q[head_q];
  assign mmu_valid   = nonempty && head_ok;
  assign in_ready    = (count_q < (PTR_W+1)'(DEPTH));
  assign push        = in_valid && in_ready;
  assign pop         = mmu_valid && mmu_ready;
  assign count       = count_q;
  assign mmu_rsv_id  = nonempty ? rsv_id_q[head_q] : '0;
  assign mmu_opcode  = nonempty ? opcode_q[head_q] : '0;
  assign mmu_address = nonempty ? base_q[head_q] + offset_q[head_q] : '0;
  assign mmu_data    = nonempty ? data_q[head_q] : '0;

  always_comb begin
    rsv_id_d  = rsv_id_q;
    opcode_d  = opcode_q;
    base_d    = base_q;
    offset_d  = offset_q;
    data_d    = data_q;
    base_ok_d = base_ok_q;
    data_ok_d = data_ok_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && cdb_fire && !base_ok_q[i] && base_q[i][RSV_ID_W-1:0] == cdb_tag) begin
        base_d[i]    = cdb_val;
        base_ok_d[i] = 1'b1;
      end
      if (occupied[i] && cdb_fire && !data_ok_q[i] && data_q[i][RSV_ID_W-1:0] == cdb_tag) begin
        data_d[i]    = cdb_val;
        data_ok_d[i] = 1'b1;
      end
    end

    if (pop) begin
      base_ok_d[head_q] = 1'b0;
      data_ok_d[head_q] = 1'b0;
      head_d            = head_q + 1'b1;
    end

    // The tail slot is never live while a push is allowed, so it cannot
    // collide with the snoop or pop updates above.
    if (push) begin
      rsv_id_d[tail_q]  = in_rsv_id;
      opcode_d[tail_q]  = in_opcode;
      offset_d[tail_q]  = in_offset;
      base_d[tail_q]    = in_base;
      base_ok_d[tail_q] = in_base_ok;
      data_d[tail_q]    = in_data;
      data_ok_d[tail_q] = in_data_ok;
      if (!in_base_ok && cdb_fire && in_base[RSV_ID_W-1:0] == cdb_tag) begin
        base_d[tail_q]    = cdb_val;
        base_ok_d[tail_q] = 1'b1;
      end
      if (!in_data_ok && cdb_fire && in_data[RSV_ID_W-1:0] == cdb_tag) begin
        data_d[tail_q]    = cdb_val;
        data_ok_d[tail_q] = 1'b1;
      end
      tail_d = tail_q + 1'b1;
    end

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      base_ok_q <= '0;
      data_ok_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      base_ok_q <= base_ok_d;
      data_ok_q <= data_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    rsv_id_q <= rsv_id_d;
    opcode_q <= opcode_d;
    base_q   <= base_d;
    offset_q <= offset_d;
    data_q   <= data_d;
  end

`ifdef MEM_ISSUE_QUEUE_PERF_EN
  logic [31:0] perf_op_q, perf_op_d, perf_mmu_q, perf_mmu_d;

  always_comb begin
    perf_op_d  = perf_op_q;
    perf_mmu_d = perf_mmu_q;
    if (nonempty && !head_ok && perf_op_q != '1)  perf_op_d  = perf_op_q + 1'b1;
    if (mmu_valid && !mmu_ready && perf_mmu_q != '1) perf_mmu_d = perf_mmu_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_op_q  <= '0;
      perf_mmu_q <= '0;
    end else begin
      perf_op_q  <= perf_op_d;
      perf_mmu_q <= perf_mmu_d;
    end
  end

  assign perf_stall_operand = perf_op_q;
  assign perf_stall_mmu     = perf_mmu_q;
`endif
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue; issued ops are checked against a scoreboard.
module tb_mem_issue_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_rsv_id;
  logic [5:0]  in_opcode;
  logic [31:0] in_base, in_offset, in_data;
  logic        in_base_ok, in_data_ok;
  logic [35:0] cdb;
  logic        cdb_fire;
  logic        mmu_valid, mmu_ready;
  logic [3:0]  mmu_rsv_id;
  logic [5:0]  mmu_opcode;
  logic [31:0] mmu_address, mmu_data;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  rsv;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  mem_issue_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rsv_id(in_rsv_id), .in_opcode(in_opcode),
    .in_base(in_base), .in_base_ok(in_base_ok),
    .in_offset(in_offset), .in_data(in_data), .in_data_ok(in_data_ok),
    .cdb(cdb), .cdb_fire(cdb_fire),
    .mmu_valid(mmu_valid), .mmu_ready(mmu_ready),
    .mmu_rsv_id(mmu_rsv_id), .mmu_opcode(mmu_opcode),
    .mmu_address(mmu_address), .mmu_data(mmu_data),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Called before the active edge: an accepted issue is compared with the oldest expectation.
  task automatic sample();
    exp_t e;
    if (mmu_valid === 1'b1 && mmu_ready === 1'b1) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected observed=rsv_id %0h expected=no issue", mmu_rsv_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("[TB] issue rsv_id=%0h addr=%08h data=%08h", mmu_rsv_id, mmu_address, mmu_data);
        chk("sb_rsv_id", mmu_rsv_id, e.rsv);
        chk("sb_opcode", mmu_opcode, e.op);
        chk("sb_address", mmu_address, e.addr);
        chk("sb_data", mmu_data, e.data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_v(input string name, input logic v);
    @(negedge clk);
    chk(name, mmu_valid, v);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] rsv, input logic [5:0] op,
                          input logic [31:0] base, input logic bok, input logic [31:0] off,
                          input logic [31:0] data, input logic dok,
                          input logic [31:0] exp_base, input logic [31:0] exp_data,
                          input logic exp_acc);
    exp_t e;
    in_valid = 1'b1; in_rsv_id = rsv; in_opcode = op;
    in_base = base; in_base_ok = bok; in_offset = off;
    in_data = data; in_data_ok = dok;
    @(negedge clk);
    chk("in_ready", in_ready, exp_acc);
    if (exp_acc) begin
      e.rsv = rsv; e.op = op; e.addr = exp_base + off; e.data = exp_data;
      sb.push_back(e);
    end
    $display("[TB] dispatch rsv_id=%0h accept=%0b", rsv, exp_acc);
    sample();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && count != 0; k++) tick();
    chk("drain_count", count, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rsv_id = '0; in_opcode = '0;
    in_base = '0; in_base_ok = 1'b0; in_offset = '0; in_data = '0; in_data_ok = 1'b0;
    cdb = '0; cdb_fire = 1'b0; mmu_ready = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", mmu_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_address", mmu_address, 0);
    chk("rst_data", mmu_data, 0);

    // resolved op
    mmu_ready = 1'b1;
    dispatch(4'd3, 6'd1, 32'h100, 1, 32'h10, 32'hDEAD, 1, 32'h100, 32'hDEAD, 1);
    tick_v("res_valid", 1);
    chk("res_count", count, 0);

    // pending base resolved by CDB three cycles later
    dispatch(4'd4, 6'd2, 32'h5, 0, 32'h8, 32'h11, 1, 32'h2000, 32'h11, 1);
    tick_v("pb_wait0", 0); tick_v("pb_wait1", 0); tick_v("pb_wait2", 0);
    cdb = {4'd5, 32'h2000}; cdb_fire = 1'b1;
    tick_v("pb_capture", 0);
    cdb_fire = 1'b0;
    tick_v("pb_issue", 1);
    chk("pb_count", count, 0);

    // same-cycle bypass of the data operand
    cdb = {4'd7, 32'h55}; cdb_fire = 1'b1;
    dispatch(4'd6, 6'd3, 32'h40, 1, 32'h0, 32'h7, 0, 32'h40, 32'h55, 1);
    cdb_fire = 1'b0;
    tick_v("byp_issue", 1);

    // head blocks a resolved younger entry
    dispatch(4'd8, 6'd4, 32'h2, 0, 32'h4, 32'h1, 1, 32'h300, 32'h1, 1);
    dispatch(4'd9, 6'd5, 32'h500, 1, 32'h0, 32'h2, 1, 32'h500, 32'h2, 1);
    tick_v("ord_block0", 0); tick_v("ord_block1", 0);
    cdb = {4'd2, 32'h300}; cdb_fire = 1'b1;
    tick_v("ord_capture", 0);
    cdb_fire = 1'b0;
    chk("ord_head", mmu_rsv_id, 8);
    tick_v("ord_first", 1);
    tick_v("ord_second", 1);
    chk("ord_count", count, 0);

    // full and backpressure
    mmu_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      dispatch(4'(10 + i), 6'd6, 32'h1000 * i, 1, 32'h4, 32'hB0 + i, 1, 32'h1000 * i, 32'hB0 + i, 1);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    dispatch(4'd15, 6'd7, 32'h0, 1, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0);
    chk("full_ignored", count, 4);
    chk("full_hold_rsv", mmu_rsv_id, 10);
    chk("full_hold_addr", mmu_address, 32'h4);
    mmu_ready = 1'b1;
    dispatch(4'd14, 6'd7, 32'h0, 1, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0);
    chk("full_pop_count", count, 3);
    chk("full_pop_in_ready", in_ready, 1);
    dispatch(4'd14, 6'd8, 32'h700, 1, 32'h1, 32'hC0, 1, 32'h700, 32'hC0, 1);
    chk("pushpop_count", count, 3);
    drain();

    // ten ops through the ring, with address wrap-around
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0)
        dispatch(4'(i), 6'(i), 32'hFFFF_FFF0, 1, 32'h20, 32'hA000 + i, 1, 32'hFFFF_FFF0, 32'hA000 + i, 1);
      else
        dispatch(4'(i), 6'(i), 32'h1000 * i, 1, 32'(i), 32'hA000 + i, 1, 32'h1000 * i, 32'hA000 + i, 1);
    end
    drain();

    // reset with entries in flight
    mmu_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      dispatch(4'(i + 1), 6'd9, 32'h80, 1, 32'h0, 32'h0, 1, 32'h80, 32'h0, 1);
    chk("pre_rst_count", count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("post_rst_count", count, 0);
    chk("post_rst_valid", mmu_valid, 0);
    chk("post_rst_address", mmu_address, 0);
    chk("post_rst_rsv", mmu_rsv_id, 0);
    mmu_ready = 1'b1;
    dispatch(4'd12, 6'd10, 32'h900, 1, 32'h9, 32'h99, 1, 32'h900, 32'h99, 1);
    tick_v("post_rst_issue", 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
